// File: rtl/py300_align_pkg.sv
// Shared lane state type, default geometry and slip counter width for the
// PY300 LVDS lane alignment controller.
package py300_align_pkg;

  localparam int               DEFAULT_LANES            = 5;
  localparam int               DEFAULT_DATA_BITS        = 10;
  localparam logic [9:0]       DEFAULT_TRAINING_PATTERN = 10'h3a6;
  localparam int               SLIP_CNT_W               = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } lane_state_t;

  // A lane counts as training from the first settle until it locks or fails.
  function automatic logic lane_is_training(input lane_state_t s);
    return (s == SETTLE) || (s == CHECK) || (s == SLIP);
  endfunction

endpackage

// File: rtl/py300_align_lane.sv
// One lane's alignment FSM: settle after every slip, look for a run of
// training words, and slip the deserializer on any mismatch.
module py300_align_lane
  import py300_align_pkg::*;
#(
  parameter int                   DATA_BITS        = DEFAULT_DATA_BITS,
  parameter logic [DATA_BITS-1:0] TRAINING_PATTERN = DATA_BITS'(DEFAULT_TRAINING_PATTERN),
  parameter int                   SETTLE_CYCLES    = 8,
  parameter int                   MATCH_COUNT      = 16,
  parameter int                   MAX_SLIPS        = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_BITS-1:0]  data,
  input  logic                  valid,
  output lane_state_t           state,
  output logic [SLIP_CNT_W-1:0] slip_count
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int MATCH_W  = $clog2(MATCH_COUNT) + 1;

  localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]    MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SLIP_CNT_W-1:0] SLIP_LIMIT  = SLIP_CNT_W'(MAX_SLIPS);

  lane_state_t           state_q, state_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [MATCH_W-1:0]    match_q, match_d;
  logic [SLIP_CNT_W-1:0] slip_q, slip_d, slip_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slip_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
    end
  end

  // A start pulse overrides every state, including a final match or slip.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
    slip_inc = (slip_q == '1) ? slip_q : slip_q + 1'b1;

    if (start) begin
      state_d  = SETTLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (valid) begin
            if (settle_q == SETTLE_LAST) begin
              settle_d = '0;
              state_d  = CHECK;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (valid) begin
            if (data == TRAINING_PATTERN) begin
              match_d = match_q + 1'b1;
              if (match_q == MATCH_LAST) begin
                state_d = LOCKED;
              end
            end else begin
              match_d = '0;
              state_d = SLIP;
            end
          end
        end
        SLIP: begin
          slip_d  = slip_inc;
          state_d = (slip_inc >= SLIP_LIMIT) ? FAIL : SETTLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign slip_count = slip_q;

endmodule

// File: rtl/py300_align_control.sv
// Trains all LVDS lanes in parallel and merges their slip requests with
// register-driven manual slips; reports busy/done and per-lane results.
module py300_align_control
  import py300_align_pkg::*;
#(
  parameter int                   LANES            = DEFAULT_LANES,
  parameter int                   DATA_BITS        = DEFAULT_DATA_BITS,
  parameter logic [DATA_BITS-1:0] TRAINING_PATTERN = DATA_BITS'(DEFAULT_TRAINING_PATTERN),
  parameter int                   SETTLE_CYCLES    = 8,
  parameter int                   MATCH_COUNT      = 16,
  parameter int                   MAX_SLIPS        = 20
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_start,
  input  logic [LANES-1:0]                      in_manual_bitslip,
  input  logic [LANES-1:0][DATA_BITS-1:0]       in_data,
  input  logic                                  in_valid,
  output logic [LANES-1:0]                      out_bitslip,
  output logic                                  out_busy,
  output logic                                  out_done,
  output logic [LANES-1:0]                      out_locked,
  output logic [LANES-1:0]                      out_error,
  output logic [LANES-1:0][SLIP_CNT_W-1:0]      out_slip_count
);

  lane_state_t                      lane_state [LANES];
  logic [LANES-1:0][SLIP_CNT_W-1:0] lane_slip_count;
  logic [LANES-1:0]                 lane_busy;
  logic                             busy_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    py300_align_lane #(
      .DATA_BITS        (DATA_BITS),
      .TRAINING_PATTERN (TRAINING_PATTERN),
      .SETTLE_CYCLES    (SETTLE_CYCLES),
      .MATCH_COUNT      (MATCH_COUNT),
      .MAX_SLIPS        (MAX_SLIPS)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .start      (in_start),
      .data       (in_data[g]),
      .valid      (in_valid),
      .state      (lane_state[g]),
      .slip_count (lane_slip_count[g])
    );
  end

  // Remembers whether training was in progress so the falling edge of busy
  // can be seen; reset clears it so an abort never produces a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |lane_busy;
    end
  end

  // Manual slips only reach a deserializer whose lane is not training.
  always_comb begin
    lane_busy      = '0;
    out_bitslip    = '0;
    out_locked     = '0;
    out_error      = '0;
    out_slip_count = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_busy[i]      = lane_is_training(lane_state[i]);
      out_bitslip[i]    = !reset && ((lane_state[i] == SLIP) ||
                                     (in_manual_bitslip[i] && !lane_busy[i]));
      out_locked[i]     = !reset && (lane_state[i] == LOCKED);
      out_error[i]      = !reset && (lane_state[i] == FAIL);
      out_slip_count[i] = reset ? '0 : lane_slip_count[i];
    end
    out_busy = !reset && (|lane_busy);
    out_done = !reset && busy_q && !(|lane_busy);
  end

endmodule

// File: doc/py300_align_control.md
PY300_ALIGN_CONTROL -- requirements
Module: py300_align_control

Interface
REQ-001 SHALL have parameter LANES, default 5, meaning the number of LVDS lanes (4 data + 1 sync).
REQ-002 SHALL have parameter DATA_BITS, default 10, meaning the deserialized word width per lane.
REQ-003 SHALL have parameter TRAINING_PATTERN, default 10'h3a6, meaning the word each lane must present when aligned.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8, meaning the in_valid samples ignored after each slip.
REQ-005 SHALL have parameter MATCH_COUNT, default 16, meaning the consecutive matching samples required to lock.
REQ-006 SHALL have parameter MAX_SLIPS, default 20, meaning the slip attempts allowed before a lane fails.
REQ-007 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_start, input, 1, a one-cycle pulse that starts or restarts training.
REQ-010 SHALL have port in_manual_bitslip, input, LANES, register-driven slip pulses.
REQ-011 SHALL have port in_data, input, LANES x DATA_BITS, deserialized lane words.
REQ-012 SHALL have port in_valid, input, 1, a qualifier common to all in_data lanes.
REQ-013 SHALL have port out_bitslip, output, LANES, one-cycle slip pulses to the deserializers.
REQ-014 SHALL have port out_busy, output, 1, asserted while any lane is training.
REQ-015 SHALL have port out_done, output, 1, a one-cycle pulse when the last training lane finishes.
REQ-016 SHALL have port out_locked, output, LANES, per-lane lock status.
REQ-017 SHALL have port out_error, output, LANES, per-lane failure status.
REQ-018 SHALL have port out_slip_count, output, LANES x 5, per-lane slips issued in the last run.

Function
REQ-019 Each lane SHALL run an independent FSM with states IDLE, SETTLE, CHECK, SLIP, LOCKED and FAIL.
REQ-020 An in_start pulse in any state SHALL move every lane to SETTLE on the next cycle, clearing its settle, match and slip counters and its locked and error flags (abort and restart).
REQ-021 SETTLE SHALL count in_valid cycles and move to CHECK on the cycle after the SETTLE_CYCLES-th valid sample; cycles without in_valid SHALL not count.
REQ-022 In CHECK, each in_valid sample equal to TRAINING_PATTERN SHALL increment the match counter; the MATCH_COUNT-th consecutive match SHALL move the lane to LOCKED.
REQ-023 In CHECK, a mismatching valid sample SHALL clear the match counter and move the lane to SLIP.
REQ-024 SLIP SHALL last exactly one cycle, drive out_bitslip[lane]=1, and increment the slip counter (saturating at 31).
REQ-025 From SLIP, the lane SHALL go to FAIL if the slip counter reaches MAX_SLIPS, otherwise to SETTLE.
REQ-026 The mismatch-to-pulse latency SHALL be 1 cycle: a mismatch sampled at cycle t gives out_bitslip high at t+1 only.
REQ-027 LOCKED and FAIL SHALL hold until in_start or reset; out_locked and out_error SHALL be registered state decodes.
REQ-028 A lane in LOCKED SHALL NOT re-slip on later mismatches; monitoring after lock is out of scope.
REQ-029 out_bitslip[i] SHALL equal FSM slip OR in_manual_bitslip[i] when lane i is in IDLE, LOCKED or FAIL; manual slips during SETTLE, CHECK or SLIP SHALL be dropped.
REQ-030 out_busy SHALL be the OR of all lanes being in SETTLE, CHECK or SLIP.
REQ-031 out_done SHALL pulse for one cycle on the cycle out_busy falls, and SHALL NOT pulse on an abort by in_start.
REQ-032 in_start coinciding with a lane's final match or final slip SHALL take priority (restart).
REQ-033 All counters SHALL be sized by $clog2 of their limit plus 1 and SHALL never wrap.

Reset
REQ-034 While reset=1, every lane SHALL be in IDLE with all counters 0.
REQ-035 While reset=1, out_bitslip, out_busy, out_done, out_locked, out_error and out_slip_count SHALL all be 0.
REQ-036 Reset asserted mid-training SHALL abort on the next edge with no out_done pulse.

Structure
REQ-037 Package py300_align_pkg SHALL hold the lane state enum, the default LANES, DATA_BITS and TRAINING_PATTERN, and the slip counter width.
REQ-038 The sub-module py300_align_lane SHALL hold one lane's FSM and counters; the top SHALL instantiate LANES copies plus the busy, done and manual-OR logic.
REQ-039 The block SHALL contain no AXI logic; in_start and in_manual_bitslip come from the register block's auto-clear pulses.

Verification
REQ-040 All lanes present 10'h3a6 continuously, in_valid=1, in_start pulses -> no out_bitslip; out_locked=5'h1f at start+1+8+16 cycles; out_done pulses once; out_slip_count all 0.
REQ-041 Lane 2 presents the pattern rotated by 3 bits, with each slip rotating it back one bit -> exactly 3 single-cycle out_bitslip[2] pulses; lane 2 locks with out_slip_count[2]=3.
REQ-042 Lane 0 is never matching -> 20 slips, then out_error[0]=1 and out_locked[0]=0; out_done pulses after the last lane finishes.
REQ-043 in_valid toggles 1/0 -> settle and match counts advance only on valid cycles, so lock time doubles versus REQ-040.
REQ-044 in_start is re-pulsed mid-training, then reset is asserted mid-training -> counters clear, no out_done pulse; after reset all outputs are 0.
REQ-045 in_manual_bitslip=5'h04 while idle -> out_bitslip=5'h04 for the same cycle; the same input while busy -> out_bitslip stays 0.
